// File: rtl/kcpe_pkg.sv
// Shared types and constants for the kernel-channel PE sequencer.
package kcpe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        ISSUE,
        WAIT,
        OUT
    } kcpe_state_e;

    localparam int ERR_SPUR_VLD   = 0;
    localparam int ERR_PART_VLD   = 1;
    localparam int ERR_TIMEOUT    = 2;
    localparam int ERR_BITS       = 3;

    localparam int KCPE_BIT_WIDTH = 8;
    localparam int PSUM_W         = 2 * KCPE_BIT_WIDTH;
    // 9 taps x 255 channel groups = 2295 beats fits in 12 bits
    localparam int BEAT_W         = 12;

endpackage

// File: rtl/kernel_channel_pe_ctrl_if.sv
// Buffer-read, PE-array and result buses of the kernel-channel sequencer.
interface kernel_channel_pe_ctrl_if
    import kcpe_pkg::*;
#(
    parameter int BIT_WIDTH   = KCPE_BIT_WIDTH,
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_KERNEL  = 4,
    parameter int ADDR_WIDTH  = 16
);
    localparam int DW = BIT_WIDTH * NUM_CHANNEL;
    localparam int WW = DW * NUM_KERNEL;
    localparam int PW = 2 * BIT_WIDTH;

    logic                           o_rd_en;
    logic [ADDR_WIDTH-1:0]          o_rd_addr;
    logic [DW-1:0]                  i_rd_data;
    logic [WW-1:0]                  i_rd_weight;
    logic [DW-1:0]                  o_pe_data;
    logic [WW-1:0]                  o_pe_weight;
    logic                           o_pe_data_vld;
    logic                           o_pe_weight_vld;
    logic [NUM_KERNEL-1:0][PW-1:0]  o_pe_psum;
    logic [NUM_KERNEL-1:0][PW-1:0]  i_pe_psum;
    logic [NUM_KERNEL-1:0]          i_pe_psum_vld;
    logic [NUM_KERNEL-1:0][PW-1:0]  o_result;
    logic                           o_result_vld;
    logic                           i_result_rdy;

    modport master (
        output o_rd_en, o_rd_addr, o_pe_data, o_pe_weight, o_pe_data_vld,
               o_pe_weight_vld, o_pe_psum, o_result, o_result_vld,
        input  i_rd_data, i_rd_weight, i_pe_psum, i_pe_psum_vld, i_result_rdy
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_pe_data, o_pe_weight, o_pe_data_vld,
               o_pe_weight_vld, o_pe_psum, o_result, o_result_vld,
        output i_rd_data, i_rd_weight, i_pe_psum, i_pe_psum_vld, i_result_rdy
    );

endinterface

// File: rtl/kcpe_beat_counter.sv
// Beat index, terminal-count detect and buffer address for one output pixel.
module kcpe_beat_counter
    import kcpe_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int KERNEL_SIZE = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_inc,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [7:0]            i_num_cgrp,
    output logic [BEAT_W-1:0]     o_beat,
    output logic                  o_last,
    output logic [ADDR_WIDTH-1:0] o_addr
);
    logic [ADDR_WIDTH-1:0] r_base;
    logic [BEAT_W-1:0]     r_beat;
    logic [BEAT_W-1:0]     r_last_idx;
    logic [7:0]            w_cgrp;
    logic [BEAT_W-1:0]     w_last_idx;

    assign w_cgrp     = (i_num_cgrp == 8'd0) ? 8'd1 : i_num_cgrp;
    assign w_last_idx = BEAT_W'(KERNEL_SIZE) * {4'd0, w_cgrp} - BEAT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_beat     <= '0;
            r_last_idx <= '0;
        end else if (i_load) begin
            r_base     <= i_base;
            r_beat     <= '0;
            r_last_idx <= w_last_idx;
        end else if (i_inc) begin
            r_beat     <= r_beat + BEAT_W'(1);
        end
    end

    assign o_beat = r_beat;
    assign o_last = (r_beat == r_last_idx);
    // natural overflow of the add gives the modulo-2^ADDR_WIDTH wrap
    assign o_addr = r_base + ADDR_WIDTH'(r_beat);

endmodule

// File: rtl/kernel_channel_pe_ctrl.sv
// Sequencer for one 3-channel x 4-kernel MAC array, one beat in flight at a time.
// Optional WAIT watchdog: define KCPE_CTRL_TIMEOUT_EN.
module kernel_channel_pe_ctrl
    import kcpe_pkg::*;
#(
    parameter int BIT_WIDTH   = KCPE_BIT_WIDTH,
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_KERNEL  = 4,
    parameter int REG_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int KERNEL_SIZE = 9,
    parameter int TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_cfg_base_addr,
    input  logic [7:0]            i_cfg_num_cgrp,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [REG_WIDTH-1:0]  err_ctrl,
    kernel_channel_pe_ctrl_if.master bus
);
    localparam int DW = BIT_WIDTH * NUM_CHANNEL;
    localparam int WW = DW * NUM_KERNEL;
    localparam int PW = 2 * BIT_WIDTH;

    kcpe_state_e                   r_state;
    logic [DW-1:0]                 r_pe_data;
    logic [WW-1:0]                 r_pe_weight;
    logic                          r_pe_vld;
    logic [NUM_KERNEL-1:0][PW-1:0] r_pe_psum;
    logic [NUM_KERNEL-1:0][PW-1:0] r_acc;
    logic [NUM_KERNEL-1:0][PW-1:0] r_result;
    logic                          r_result_vld;
    logic                          r_done;
    logic [ERR_BITS-1:0]           r_err;
`ifdef KCPE_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]               r_to_cnt;
`endif

    logic [BEAT_W-1:0]             w_beat;
    logic                          w_last;
    logic [ADDR_WIDTH-1:0]         w_addr;
    logic                          w_load;
    logic                          w_inc;
    logic                          w_all_vld;
    logic                          w_any_vld;

    assign w_all_vld = &bus.i_pe_psum_vld;
    assign w_any_vld = |bus.i_pe_psum_vld;
    assign w_load    = (r_state == IDLE) && i_start;
    assign w_inc     = (r_state == WAIT) && w_all_vld && !w_last;

    kcpe_beat_counter #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .KERNEL_SIZE (KERNEL_SIZE)
    ) u_beat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_inc      (w_inc),
        .i_base     (i_cfg_base_addr),
        .i_num_cgrp (i_cfg_num_cgrp),
        .o_beat     (w_beat),
        .o_last     (w_last),
        .o_addr     (w_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pe_data    <= '0;
            r_pe_weight  <= '0;
            r_pe_vld     <= 1'b0;
            r_pe_psum    <= '0;
            r_acc        <= '0;
            r_result     <= '0;
            r_result_vld <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= '0;
`ifdef KCPE_CTRL_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            // protocol errors are only flagged; the FSM carries on regardless
            if (r_state != WAIT && w_any_vld)
                r_err[ERR_SPUR_VLD] <= 1'b1;
            if (r_state == WAIT && w_any_vld && !w_all_vld)
                r_err[ERR_PART_VLD] <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_acc   <= '0;
                        r_state <= RD;
                    end
                end
                RD: r_state <= ISSUE;
                ISSUE: begin
                    r_pe_data   <= bus.i_rd_data;
                    r_pe_weight <= bus.i_rd_weight;
                    r_pe_vld    <= 1'b1;
                    r_pe_psum   <= (w_beat == '0) ? '0 : r_acc;
`ifdef KCPE_CTRL_TIMEOUT_EN
                    r_to_cnt    <= '0;
`endif
                    r_state     <= WAIT;
                end
                WAIT: begin
                    r_pe_vld <= 1'b0;
                    if (w_all_vld) begin
                        r_acc <= bus.i_pe_psum;
                        if (w_last) begin
                            r_result     <= bus.i_pe_psum;
                            r_result_vld <= 1'b1;
                            r_state      <= OUT;
                        end else begin
                            r_state      <= RD;
                        end
                    end
`ifdef KCPE_CTRL_TIMEOUT_EN
                    else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                        r_err[ERR_TIMEOUT] <= 1'b1;
                        r_state            <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
`endif
                end
                OUT: begin
                    if (bus.i_result_rdy) begin
                        r_result_vld <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy              = (r_state != IDLE);
    assign o_done              = r_done;
    assign err_ctrl            = REG_WIDTH'(r_err);
    assign bus.o_rd_en         = (r_state == RD);
    assign bus.o_rd_addr       = w_addr;
    assign bus.o_pe_data       = r_pe_data;
    assign bus.o_pe_weight     = r_pe_weight;
    assign bus.o_pe_data_vld   = r_pe_vld;
    assign bus.o_pe_weight_vld = r_pe_vld;
    assign bus.o_pe_psum       = r_pe_psum;
    assign bus.o_result        = r_result;
    assign bus.o_result_vld    = r_result_vld;

endmodule

// File: tb/tb_kernel_channel_pe_ctrl.sv
// Randomized bench: buffer + MAC array models, result checked against a direct dot-product sum.
module tb_kernel_channel_pe_ctrl;
    typedef logic [3:0][15:0] psum_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_cfg_base_addr = '0;
    logic [7:0]  i_cfg_num_cgrp = '0;
    logic        o_busy, o_done;
    logic [31:0] err_ctrl;

    kernel_channel_pe_ctrl_if bus ();

    kernel_channel_pe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_cfg_base_addr (i_cfg_base_addr),
        .i_cfg_num_cgrp  (i_cfg_num_cgrp),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .err_ctrl        (err_ctrl),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [23:0] mem_d [64];
    logic [95:0] mem_w [64];

    // buffer: data one cycle after the read strobe
    always @(posedge clk) begin
        if (bus.o_rd_en) begin
            bus.i_rd_data   <= mem_d[bus.o_rd_addr[5:0]];
            bus.i_rd_weight <= mem_w[bus.o_rd_addr[5:0]];
        end
    end

    // MAC array model: psum_out[k] = psum_in[k] + sum_c d[c]*w[k][c], after lat cycles
    int          mode = 0;   // 0 normal, 1 never respond, 2 partial valid
    int          lat  = 1;
    int          arr_cnt;
    logic [3:0]  arr_vld;
    logic [3:0]  inj_vld = '0;
    assign bus.i_pe_psum_vld = arr_vld | inj_vld;

    function automatic psum_t mac(input psum_t pin, input logic [23:0] d, input logic [95:0] w);
        psum_t s;
        s = pin;
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 3; c++)
                s[k] = s[k] + 16'(d[c*8 +: 8]) * 16'(w[(k*3+c)*8 +: 8]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            arr_cnt <= 0;
            arr_vld <= '0;
        end else begin
            arr_vld <= '0;
            if (bus.o_pe_data_vld) begin
                bus.i_pe_psum <= mac(bus.o_pe_psum, bus.o_pe_data, bus.o_pe_weight);
                if (lat == 1) begin
                    if (mode != 1) arr_vld <= (mode == 2) ? 4'b0011 : 4'b1111;
                end else begin
                    arr_cnt <= lat - 1;
                end
            end else if (arr_cnt != 0) begin
                arr_cnt <= arr_cnt - 1;
                if (arr_cnt == 1 && mode != 1) arr_vld <= (mode == 2) ? 4'b0011 : 4'b1111;
            end
        end
    end

    logic [15:0] rd_q[$];
    psum_t       psum_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_rd_en)       rd_q.push_back(bus.o_rd_addr);
            if (bus.o_pe_data_vld) psum_q.push_back(bus.o_pe_psum);
            if (o_done)            done_cnt++;
        end
    end

    // reference: total of the first nb beats straight from the buffer contents
    function automatic psum_t ref_sum(input logic [15:0] base, input int nb);
        psum_t s;
        s = '0;
        for (int b = 0; b < nb; b++) begin
            logic [15:0] a;
            a = base + 16'(b);
            s = mac(s, mem_d[a[5:0]], mem_w[a[5:0]]);
        end
        return s;
    endfunction

    function automatic int nbeats(input logic [7:0] cg);
        return 9 * ((cg == 8'd0) ? 1 : int'(cg));
    endfunction

    task automatic fill_mem(input bit ones);
        for (int i = 0; i < 64; i++) begin
            mem_d[i] = ones ? 24'h010101 : 24'($urandom);
            mem_w[i] = ones ? {12{8'h01}} : {$urandom, $urandom, $urandom};
        end
    endtask

    task automatic clear_logs();
        rd_q.delete();
        psum_q.delete();
        done_cnt = 0;
    endtask

    // start a pixel, wait for the result, accept it at once
    task automatic do_pixel(input logic [15:0] base, input logic [7:0] cg, output bit to, output psum_t res);
        int cyc;
        clear_logs();
        @(negedge clk);
        i_start = 1'b1; i_cfg_base_addr = base; i_cfg_num_cgrp = cg;
        @(negedge clk);
        i_start = 1'b0; i_cfg_base_addr = 16'($urandom); i_cfg_num_cgrp = 8'($urandom);
        cyc = 0;
        while (!bus.o_result_vld && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        to  = (cyc >= 4000);
        res = bus.o_result;
        bus.i_result_rdy = 1'b1;
        @(negedge clk);
        bus.i_result_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        vectors++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_done); end
        vectors++; if (err_ctrl !== 32'h0) begin errors++; $display("FAIL reset_err got=%h exp=0", err_ctrl); end
        vectors++; if (bus.o_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", bus.o_rd_en); end
        vectors++; if (bus.o_rd_addr !== 16'h0) begin errors++; $display("FAIL reset_rd_addr got=%h exp=0", bus.o_rd_addr); end
        vectors++; if ({bus.o_pe_data_vld, bus.o_pe_weight_vld} !== 2'b00) begin errors++; $display("FAIL reset_pe_vld got=%b exp=00", {bus.o_pe_data_vld, bus.o_pe_weight_vld}); end
        vectors++; if (bus.o_pe_psum !== '0) begin errors++; $display("FAIL reset_pe_psum got=%h exp=0", bus.o_pe_psum); end
        vectors++; if (bus.o_result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.o_result); end
        vectors++; if (bus.o_result_vld !== 1'b0) begin errors++; $display("FAIL reset_result_vld got=%b exp=0", bus.o_result_vld); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_ones(input logic [7:0] cg, input string nm);
        bit to; psum_t res; psum_t exp;
        fill_mem(1'b1);
        mode = 0; lat = 1;
        do_pixel(16'h0040, cg, to, res);
        for (int k = 0; k < 4; k++) exp[k] = 16'd27;
        vectors++; if (to) begin errors++; $display("FAIL %s_timeout got=no_result exp=result", nm); end
        vectors++; if (res !== exp) begin errors++; $display("FAIL %s_result got=%h exp=%h", nm, res, exp); end
        vectors++; if (rd_q.size() != 9) begin errors++; $display("FAIL %s_reads got=%0d exp=9", nm, rd_q.size()); end
        for (int i = 0; i < rd_q.size(); i++) begin
            vectors++; if (rd_q[i] !== 16'h0040 + 16'(i)) begin errors++; $display("FAIL %s_addr%0d got=%h exp=%h", nm, i, rd_q[i], 16'h0040 + 16'(i)); end
        end
        vectors++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done got=%0d exp=1", nm, done_cnt); end
        vectors++; if (o_busy !== 1'b0) begin errors++; $display("FAIL %s_idle got=%b exp=0", nm, o_busy); end
    endtask

    task automatic test_wrap();
        bit to; psum_t res; psum_t exp;
        fill_mem(1'b0);
        mode = 0; lat = 2;
        do_pixel(16'hFFFC, 8'd2, to, res);
        exp = ref_sum(16'hFFFC, 18);
        vectors++; if (to) begin errors++; $display("FAIL wrap_timeout got=no_result exp=result"); end
        vectors++; if (res !== exp) begin errors++; $display("FAIL wrap_result got=%h exp=%h", res, exp); end
        vectors++; if (rd_q.size() != 18) begin errors++; $display("FAIL wrap_reads got=%0d exp=18", rd_q.size()); end
        for (int i = 0; i < rd_q.size(); i++) begin
            vectors++; if (rd_q[i] !== 16'hFFFC + 16'(i)) begin errors++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, rd_q[i], 16'hFFFC + 16'(i)); end
        end
        vectors++; if (psum_q.size() != 18) begin errors++; $display("FAIL wrap_beats got=%0d exp=18", psum_q.size()); end
        for (int i = 0; i < psum_q.size(); i++) begin
            vectors++; if (psum_q[i] !== ref_sum(16'hFFFC, i)) begin errors++; $display("FAIL wrap_psum%0d got=%h exp=%h", i, psum_q[i], ref_sum(16'hFFFC, i)); end
        end
    endtask

    task automatic test_hold();
        int cyc; psum_t res0; psum_t exp;
        fill_mem(1'b0);
        mode = 0; lat = 1;
        clear_logs();
        @(negedge clk);
        i_start = 1'b1; i_cfg_base_addr = 16'h0123; i_cfg_num_cgrp = 8'd1;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 0;
        while (!bus.o_result_vld && cyc < 4000) begin @(negedge clk); cyc++; end
        vectors++; if (cyc >= 4000) begin errors++; $display("FAIL hold_timeout got=no_result exp=result"); end
        res0 = bus.o_result;
        exp  = ref_sum(16'h0123, 9);
        vectors++; if (res0 !== exp) begin errors++; $display("FAIL hold_result got=%h exp=%h", res0, exp); end
        for (int i = 0; i < 5; i++) begin
            i_start = (i % 2 == 0);
            @(negedge clk);
            vectors++; if (bus.o_result !== res0 || bus.o_result_vld !== 1'b1) begin errors++; $display("FAIL hold_stable%0d got=%h/%b exp=%h/1", i, bus.o_result, bus.o_result_vld, res0); end
            vectors++; if (done_cnt != 0) begin errors++; $display("FAIL hold_nodone%0d got=%0d exp=0", i, done_cnt); end
        end
        i_start = 1'b0;
        bus.i_result_rdy = 1'b1;
        @(negedge clk);
        bus.i_result_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (done_cnt != 1) begin errors++; $display("FAIL hold_done got=%0d exp=1", done_cnt); end
        vectors++; if (o_busy !== 1'b0 || rd_q.size() != 9) begin errors++; $display("FAIL hold_start_ignored got=busy%b/reads%0d exp=busy0/reads9", o_busy, rd_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit to; psum_t res; psum_t exp;
        logic [15:0] base; logic [7:0] cg;
        fill_mem(1'b0);
        mode = 0;
        for (int n = 0; n < 6; n++) begin
            base = 16'($urandom);
            cg   = 8'($urandom_range(0, 3));
            lat  = $urandom_range(1, 3);
            do_pixel(base, cg, to, res);
            exp = ref_sum(base, nbeats(cg));
            vectors++; if (to || res !== exp) begin errors++; $display("FAIL b2b%0d_result got=%h exp=%h to=%0d", n, res, exp, to); end
            vectors++; if (rd_q.size() != nbeats(cg)) begin errors++; $display("FAIL b2b%0d_reads got=%0d exp=%0d", n, rd_q.size(), nbeats(cg)); end
            vectors++; if (done_cnt != 1) begin errors++; $display("FAIL b2b%0d_done got=%0d exp=1", n, done_cnt); end
        end
    endtask

    task automatic test_errors();
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        inj_vld = 4'b0100;
        @(negedge clk);
        inj_vld = 4'b0000;
        @(negedge clk);
        vectors++; if (err_ctrl !== 32'h1) begin errors++; $display("FAIL err_spurious got=%h exp=00000001", err_ctrl); end
        mode = 2; lat = 1;
        i_start = 1'b1; i_cfg_base_addr = 16'h0; i_cfg_num_cgrp = 8'd1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        vectors++; if (err_ctrl !== 32'h3) begin errors++; $display("FAIL err_partial got=%h exp=00000003", err_ctrl); end
        vectors++; if (o_busy !== 1'b1) begin errors++; $display("FAIL err_still_waiting got=%b exp=1", o_busy); end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        mode = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout_and_midreset();
        int busy_cyc;
        clear_logs();
        mode = 1; lat = 1;
        @(negedge clk);
        i_start = 1'b1; i_cfg_base_addr = 16'h0010; i_cfg_num_cgrp = 8'd1;
        @(negedge clk);
        i_start = 1'b0;
`ifdef KCPE_CTRL_TIMEOUT_EN
        busy_cyc = 0;
        while (o_busy && busy_cyc < 200) begin @(negedge clk); busy_cyc++; end
        // RD + ISSUE + 64 WAIT cycles
        vectors++; if (busy_cyc != 66) begin errors++; $display("FAIL timeout_cycles got=%0d exp=66", busy_cyc); end
        vectors++; if (err_ctrl !== 32'h4) begin errors++; $display("FAIL timeout_err got=%h exp=00000004", err_ctrl); end
        vectors++; if (done_cnt != 0) begin errors++; $display("FAIL timeout_nodone got=%0d exp=0", done_cnt); end
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
`else
        busy_cyc = 0;
        repeat (100) begin @(negedge clk); if (o_busy) busy_cyc++; end
        vectors++; if (busy_cyc != 100) begin errors++; $display("FAIL wait_forever got=%0d exp=100", busy_cyc); end
        vectors++; if (err_ctrl !== 32'h0) begin errors++; $display("FAIL wait_noerr got=%h exp=00000000", err_ctrl); end
`endif
        vectors++; if (o_busy !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy got=%b exp=1", o_busy); end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({o_busy, o_done, err_ctrl, bus.o_rd_en, bus.o_rd_addr, bus.o_pe_data_vld, bus.o_pe_weight_vld,
             bus.o_pe_data, bus.o_pe_weight, bus.o_pe_psum, bus.o_result, bus.o_result_vld} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got=busy%b err%h addr%h psum%h exp=all_zero", o_busy, err_ctrl, bus.o_rd_addr, bus.o_pe_psum);
        end
        rst = 1'b0;
        mode = 0;
        repeat (3) @(negedge clk);
        vectors++; if (done_cnt != 0) begin errors++; $display("FAIL midreset_nodone got=%0d exp=0", done_cnt); end
    endtask

    initial begin
        bus.i_result_rdy = 1'b0;
        bus.i_rd_data    = '0;
        bus.i_rd_weight  = '0;
        bus.i_pe_psum    = '0;
        test_reset();
        test_basic_ones(8'd1, "cgrp1");
        test_basic_ones(8'd0, "cgrp0");
        test_wrap();
        test_hold();
        test_back_to_back();
        test_errors();
        test_timeout_and_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
